// File: rtl/fft_bin_reader.sv
// rtl/fft_bin_reader.sv - xfft output reader: frame length check, bin window forwarding, header and zero padding
module fft_bin_reader #(
  parameter int FFT_LEN            = 8192,
  parameter int FFT_CHANNELS       = 2,
  parameter int FFT_AXI_DATA_WIDTH = 32,
  parameter int BIN_START          = 0,
  parameter int BIN_COUNT          = 4096,
  parameter int HDR_EN             = 1
) (
  input  logic                                       aclk,
  input  logic                                       aresetn,
  input  logic [FFT_CHANNELS*FFT_AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                                       s_axis_tvalid,
  input  logic                                       s_axis_tlast,
  output logic                                       s_axis_tready,
  output logic [FFT_CHANNELS*FFT_AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                                       m_axis_tvalid,
  output logic                                       m_axis_tlast,
  input  logic                                       m_axis_tready,
  output logic [31:0]                                frame_count,
  output logic                                       err_tlast_unexpected,
  output logic                                       err_tlast_missing,
  output logic                                       busy
);

  localparam int W   = FFT_CHANNELS * FFT_AXI_DATA_WIDTH;
  localparam int BIW = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
  localparam int OCW = $clog2(BIN_COUNT + 1);
  localparam logic [BIW-1:0] BIN_LAST = BIW'(FFT_LEN - 1);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(BIN_COUNT - 1);
  localparam logic [OCW-1:0] OUT_FULL = OCW'(BIN_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PASS, S_PAD} state_t;

  state_t         state, state_nx;
  logic [BIW-1:0] bin_idx, bin_idx_nx;
  logic [OCW-1:0] out_cnt, out_cnt_nx;
  logic [31:0]    bin_idx_w;
  logic [63:0]    hdr_word;
  logic [W-1:0]   ld_data;
  logic           out_free, ld, ld_last, accept, in_window, last_bin, fc_inc;
  logic           err_unexp_nx, err_miss_nx;

  assign out_free  = !m_axis_tvalid || m_axis_tready;
  assign fc_inc    = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign last_bin  = (bin_idx == BIN_LAST);
  assign bin_idx_w = 32'(bin_idx);
  assign in_window = (bin_idx_w >= 32'(BIN_START)) && (bin_idx_w < 32'(BIN_START + BIN_COUNT));
  // A previous frame's tlast may be handshaking in the same cycle the header loads.
  assign hdr_word  = {frame_count + {31'd0, fc_inc}, 16'hFFDA, 16'(BIN_COUNT)};
  assign busy      = (state != S_IDLE) || m_axis_tvalid;

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bin_idx_nx    = bin_idx;
    out_cnt_nx    = out_cnt;
    s_axis_tready = 1'b0;
    accept        = 1'b0;
    ld            = 1'b0;
    ld_last       = 1'b0;
    ld_data       = '0;
    err_unexp_nx  = 1'b0;
    err_miss_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        out_cnt_nx = '0;
        if (s_axis_tvalid) state_nx = (HDR_EN != 0) ? S_HDR : S_PASS;
      end
      S_HDR: begin
        if (out_free) begin
          ld       = 1'b1;
          ld_data  = W'(hdr_word);
          state_nx = S_PASS;
        end
      end
      S_PASS: begin
        s_axis_tready = in_window ? out_free : 1'b1;
        accept        = s_axis_tvalid && s_axis_tready;
        if (accept) begin
          bin_idx_nx = bin_idx + 1'b1;
          if (in_window) begin
            ld         = 1'b1;
            ld_data    = s_axis_tdata;
            ld_last    = (out_cnt == OUT_LAST);
            out_cnt_nx = out_cnt + 1'b1;
          end
          if (s_axis_tlast || last_bin) begin
            bin_idx_nx   = '0;
            err_unexp_nx = s_axis_tlast && !last_bin;
            err_miss_nx  = !s_axis_tlast && last_bin;
            state_nx     = (out_cnt_nx < OUT_FULL) ? S_PAD : S_IDLE;
          end
        end
      end
      S_PAD: begin
        if (out_free) begin
          ld         = 1'b1;
          ld_last    = (out_cnt == OUT_LAST);
          out_cnt_nx = out_cnt + 1'b1;
          if (ld_last) state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bin_idx              <= '0;
      out_cnt              <= '0;
      m_axis_tdata         <= '0;
      m_axis_tvalid        <= 1'b0;
      m_axis_tlast         <= 1'b0;
      frame_count          <= '0;
      err_tlast_unexpected <= 1'b0;
      err_tlast_missing    <= 1'b0;
    end else begin
      bin_idx              <= bin_idx_nx;
      out_cnt              <= out_cnt_nx;
      err_tlast_unexpected <= err_unexp_nx;
      err_tlast_missing    <= err_miss_nx;
      if (ld) begin
        m_axis_tdata  <= ld_data;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= ld_last;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (fc_inc) frame_count <= frame_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fft_bin_reader.sv
// tb/tb_fft_bin_reader.sv - scoreboard bench for fft_bin_reader (windowed and full-frame configurations)
module tb_fft_bin_reader;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } beat_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [63:0] s_tdata_a = '0, m_tdata_a, s_tdata_b = '0, m_tdata_b;
  logic        s_tvalid_a = 1'b0, s_tlast_a = 1'b0, s_tready_a;
  logic        s_tvalid_b = 1'b0, s_tlast_b = 1'b0, s_tready_b;
  logic        m_tvalid_a, m_tlast_a, m_tready_a = 1'b1;
  logic        m_tvalid_b, m_tlast_b, m_tready_b = 1'b1;
  logic [31:0] fc_a, fc_b;
  logic        eu_a, em_a, busy_a, eu_b, em_b, busy_b;

  fft_bin_reader #(.FFT_LEN(16), .FFT_CHANNELS(2), .FFT_AXI_DATA_WIDTH(32),
                   .BIN_START(4), .BIN_COUNT(8), .HDR_EN(1)) dut_a (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata_a), .s_axis_tvalid(s_tvalid_a), .s_axis_tlast(s_tlast_a),
    .s_axis_tready(s_tready_a),
    .m_axis_tdata(m_tdata_a), .m_axis_tvalid(m_tvalid_a), .m_axis_tlast(m_tlast_a),
    .m_axis_tready(m_tready_a),
    .frame_count(fc_a), .err_tlast_unexpected(eu_a), .err_tlast_missing(em_a), .busy(busy_a));

  fft_bin_reader #(.FFT_LEN(16), .FFT_CHANNELS(2), .FFT_AXI_DATA_WIDTH(32),
                   .BIN_START(0), .BIN_COUNT(16), .HDR_EN(0)) dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata_b), .s_axis_tvalid(s_tvalid_b), .s_axis_tlast(s_tlast_b),
    .s_axis_tready(s_tready_b),
    .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tlast(m_tlast_b),
    .m_axis_tready(m_tready_b),
    .frame_count(fc_b), .err_tlast_unexpected(eu_b), .err_tlast_missing(em_b), .busy(busy_b));

  beat_t exp_a[$], exp_b[$];
  beat_t ea, eb;
  int total = 0, bad = 0;
  int nu_a = 0, nm_a = 0, nerr_b = 0;
  int exp_fc_a = 0, exp_nu_a = 0, exp_nm_a = 0;
  logic rnd_a = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] hdr(input int fc, input int bc);
    return {32'(fc), 16'hFFDA, 16'(bc)};
  endfunction

  function automatic logic [63:0] bin_data(input int tag, input int b);
    return {32'(tag), 32'(b)};
  endfunction

  always @(negedge aclk) begin
    if (m_tvalid_a && m_tready_a) begin
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL out_a_extra: got %h want no beat", m_tdata_a);
      end else begin
        ea = exp_a.pop_front();
        chk("out_a_data", m_tdata_a, ea.d);
        chk("out_a_last", 64'(m_tlast_a), 64'(ea.l));
      end
    end
    if (m_tvalid_b && m_tready_b) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL out_b_extra: got %h want no beat", m_tdata_b);
      end else begin
        eb = exp_b.pop_front();
        chk("out_b_data", m_tdata_b, eb.d);
        chk("out_b_last", 64'(m_tlast_b), 64'(eb.l));
      end
    end
    if (eu_a) nu_a++;
    if (em_a) nm_a++;
    if (eu_b || em_b) nerr_b++;
  end

  always begin
    @(posedge aclk);
    #1;
    m_tready_a = rnd_a ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_a(input logic [63:0] d, input logic l, input logic chk_rdy);
    int n = 0;
    s_tdata_a = d; s_tlast_a = l; s_tvalid_a = 1'b1;
    @(negedge aclk);
    if (chk_rdy) chk("s_ready_a_out_of_window", 64'(s_tready_a), 64'd1);
    while (!s_tready_a && n < 200) begin @(negedge aclk); n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL send_a_timeout: got ready=0 want 1");
    end
    @(posedge aclk); #1;
    s_tvalid_a = 1'b0; s_tlast_a = 1'b0;
  endtask

  task automatic send_b(input logic [63:0] d, input logic l);
    int n = 0;
    s_tdata_b = d; s_tlast_b = l; s_tvalid_b = 1'b1;
    @(negedge aclk);
    while (!s_tready_b && n < 200) begin @(negedge aclk); n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL send_b_timeout: got ready=0 want 1");
    end
    @(posedge aclk); #1;
    s_tvalid_b = 1'b0; s_tlast_b = 1'b0;
  endtask

  // Window is bins 4..11; bins past the last accepted one are zero pads.
  task automatic frame_a(input int tlast_at, input int nbeats, input int tag);
    int endb = nbeats - 1;
    exp_a.push_back('{hdr(exp_fc_a, 8), 1'b0});
    for (int b = 4; b <= 11; b++)
      exp_a.push_back('{(b <= endb) ? bin_data(tag, b) : 64'd0, (b == 11)});
    exp_fc_a++;
    if (tlast_at >= 0 && tlast_at < 15) exp_nu_a++;
    if (tlast_at < 0) exp_nm_a++;
    for (int b = 0; b < nbeats; b++)
      send_a(bin_data(tag, b), (b == tlast_at), ((b >= 1 && b < 4) || b >= 12));
  endtask

  task automatic drain_check(input string name);
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 500) begin
      @(negedge aclk); n++;
    end
    repeat (3) @(negedge aclk);
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      total++; bad++;
      $display("FAIL %s_drain: got %0d beats outstanding want 0", name, exp_a.size() + exp_b.size());
      exp_a.delete(); exp_b.delete();
    end
    chk({name, "_frame_count"}, 64'(fc_a), 64'(exp_fc_a));
    chk({name, "_err_unexpected"}, 64'(nu_a), 64'(exp_nu_a));
    chk({name, "_err_missing"}, 64'(nm_a), 64'(exp_nm_a));
    chk({name, "_busy"}, 64'(busy_a), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_m_tvalid", 64'(m_tvalid_a), 64'd0);
    chk("rst_m_tdata", m_tdata_a, 64'd0);
    chk("rst_s_tready", 64'(s_tready_a), 64'd0);
    chk("rst_frame_count", 64'(fc_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    frame_a(15, 16, 16'h1);
    drain_check("s1_ramp");

    rnd_a = 1'b1;
    frame_a(15, 16, 16'h2);
    frame_a(15, 16, 16'h3);
    drain_check("s2_random_ready");
    rnd_a = 1'b0;

    frame_a(7, 8, 16'h4);
    drain_check("s3_early_tlast");

    frame_a(-1, 16, 16'h5);
    frame_a(15, 16, 16'h6);
    drain_check("s4_missing_tlast");

    exp_a.push_back('{hdr(exp_fc_a, 8), 1'b0});
    for (int b = 4; b <= 6; b++) exp_a.push_back('{bin_data(16'h7, b), 1'b0});
    for (int b = 0; b <= 6; b++) send_a(bin_data(16'h7, b), 1'b0, (b >= 1 && b < 4));
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("s5_rst_m_tvalid", 64'(m_tvalid_a), 64'd0);
    chk("s5_rst_m_tlast", 64'(m_tlast_a), 64'd0);
    chk("s5_rst_m_tdata", m_tdata_a, 64'd0);
    chk("s5_rst_frame_count", 64'(fc_a), 64'd0);
    chk("s5_rst_busy", 64'(busy_a), 64'd0);
    exp_fc_a = 0;
    frame_a(15, 16, 16'h8);
    drain_check("s5_after_reset");

    for (int f = 0; f < 3; f++)
      for (int b = 0; b < 16; b++) exp_b.push_back('{bin_data(f, b), (b == 15)});
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < 16; b++) send_b(bin_data(f, b), (b == 15));
    drain_check("s6_nohdr");
    chk("s6_frame_count", 64'(fc_b), 64'd3);
    chk("s6_errors", 64'(nerr_b), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
